// File: rtl/power_pkg.sv
// rtl/power_pkg.sv - shared types and Q10.10 constants for the power calculator
// Contents: state_t FSM encoding, FRAC_BITS, DATA_W, EXP_W, ONE (1.0 in Q10.10).
package power_pkg;

    localparam int FRAC_BITS = 10;
    localparam int DATA_W    = 20;
    localparam int EXP_W     = 3;
    localparam int PROD_W    = 2 * DATA_W;

    localparam logic [DATA_W-1:0] ONE = 20'h00400;
    localparam logic [DATA_W-1:0] SAT = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/power_calc_if.sv
// rtl/power_calc_if.sv - request/response bundle of the power calculator
// Signals: in_valid, in_data_1 (x, Q10.10), in_data_2 (n), out_valid, out_data (x^n).
// Modports: master = requester (drives in_*), slave = calculator (drives out_*).
interface power_calc_if;
    import power_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data_1;
    logic [EXP_W-1:0]  in_data_2;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data_1,
        output in_data_2,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data_1,
        input  in_data_2,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/power_calc_core.sv
// rtl/power_calc_core.sv - IDLE/CALC/OUTPUT sequencer computing x^n by repeated multiply
// Ports: clk, rst_n (async, active low), io (power_calc_if.slave).
// Option: POWER_CALC_SATURATE_EN - report 20'hFFFFF when any step overflowed;
// otherwise the wrapped low 20 bits of the accumulator are reported.
module power_calc_core
    import power_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    power_calc_if.slave  io
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] x_q;
    logic [EXP_W-1:0]  n_q;
    logic [DATA_W-1:0] acc;
    logic [EXP_W-1:0]  count;
    logic              ovf;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] mul_res;
    logic              mul_ovf;
    logic [DATA_W-1:0] result;

    power_mul u_mul (
        .a   (acc),
        .b   (x_q),
        .res (mul_res),
        .ovf (mul_ovf)
    );

`ifdef POWER_CALC_SATURATE_EN
    assign result = ovf ? SAT : acc;
`else
    assign result = acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.in_valid) state_nxt = CALC;
            CALC:    if (count == n_q) state_nxt = OUTPUT;
            OUTPUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are latched at capture so later input activity cannot disturb
    // the request in flight; in_valid is only looked at in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            n_q         <= '0;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        x_q   <= io.in_data_1;
                        n_q   <= io.in_data_2;
                        acc   <= ONE;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                CALC: begin
                    // The cycle with count == n only moves to OUTPUT.
                    if (count != n_q) begin
                        acc   <= mul_res;
                        count <= count + 1'b1;
                        ovf   <= ovf | mul_ovf;
                    end
                end
                OUTPUT: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= result;
                end
                default: ;
            endcase
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;

endmodule

// File: rtl/power_mul.sv
// rtl/power_mul.sv - combinational Q10.10 x Q10.10 multiply with truncation
// Ports: a, b (Q10.10 operands) -> res (Q10.10, fraction truncated), ovf (integer
// part of the product does not fit in 10 bits).
module power_mul
    import power_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              ovf
);

    logic [PROD_W-1:0] prod;

    always_comb begin
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        // Dropping the low FRAC_BITS truncates; bits above the Q10.10 window
        // are lost from res and reported through ovf instead.
        res  = prod[DATA_W+FRAC_BITS-1:FRAC_BITS];
        ovf  = |prod[PROD_W-1:DATA_W+FRAC_BITS];
    end

endmodule

// File: rtl/power_calc.sv
// rtl/power_calc.sv - top of the Q10.10 integer-power calculator (out = x^n)
// Ports: clk, rst_n (async, active low), in_valid, in_data_1 (x, Q10.10),
// in_data_2 (n, 0..7), out_valid (one-cycle result strobe), out_data (x^n, Q10.10).
// Option: POWER_CALC_SATURATE_EN - saturate to 20'hFFFFF on overflow.
module power_calc
    import power_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [EXP_W-1:0]  in_data_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    power_calc_if io ();

    assign io.in_valid  = in_valid;
    assign io.in_data_1 = in_data_1;
    assign io.in_data_2 = in_data_2;
    assign out_valid    = io.out_valid;
    assign out_data     = io.out_data;

    power_calc_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

endmodule

// File: tb/tb_power_calc.sv
// tb/tb_power_calc.sv - directed self-checking bench for power_calc
module tb_power_calc;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    power_calc_if bus ();

    power_calc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_data_1 (bus.in_data_1),
        .in_data_2 (bus.in_data_2),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse one request, scramble inputs after capture, then wait (bounded)
    // for out_valid; lat counts rising edges after the capture edge.
    task automatic run_req(input logic [19:0] x, input logic [2:0] n,
                           output int lat, output logic [19:0] data);
        bus.in_valid  = 1'b1;
        bus.in_data_1 = x;
        bus.in_data_2 = n;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_data_1 = 20'h5A5A5;
        bus.in_data_2 = 3'd5;
        lat  = -1;
        data = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat  = i;
                data = bus.out_data;
                break;
            end
        end
    endtask

    task automatic req_check(input string tag, input logic [19:0] x, input logic [2:0] n,
                             input logic [19:0] exp_data, input int exp_lat);
        int          lat;
        logic [19:0] data;
        run_req(x, n, lat, data);
        check({tag, "_data"}, {12'h0, data}, {12'h0, exp_data});
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {31'h0, bus.out_valid}, 32'h0);
        check({tag, "_data_zero"}, {12'h0, bus.out_data}, 32'h0);
    endtask

    initial begin
        int          pulses;
        int          first_lat;
        logic [19:0] first_data;
        logic [19:0] sat_exp;

        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data_1 = '0;
        bus.in_data_2 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("reset_out_data", {12'h0, bus.out_data}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        req_check("two_cubed", 20'h00800, 3'd3, 20'h02000, 5);
        req_check("n0_any_x", 20'h12345, 3'd0, 20'h00400, 2);
        req_check("n0_x_zero", 20'h00000, 3'd0, 20'h00400, 2);
        req_check("n1", 20'h00A80, 3'd1, 20'h00A80, 3);
        req_check("half_sq", 20'h00200, 3'd2, 20'h00100, 4);
        req_check("trunc_sq", 20'h00180, 3'd2, 20'h00090, 4);
        req_check("zero_pow", 20'h00000, 3'd4, 20'h00000, 6);
        req_check("n7_latency", 20'h00400, 3'd7, 20'h00400, 9);

`ifdef POWER_CALC_SATURATE_EN
        sat_exp = 20'hFFFFF;
`else
        sat_exp = 20'h00000;
`endif
        req_check("overflow", 20'h08000, 3'd2, sat_exp, 4);

        // Second pulse during CALC must be ignored.
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 20'h00800;
        bus.in_data_2 = 3'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        pulses     = 0;
        first_lat  = -1;
        first_data = '0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 2) begin
                bus.in_valid  = 1'b1;
                bus.in_data_1 = 20'h00C00;
                bus.in_data_2 = 3'd1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.out_valid) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat  = i;
                    first_data = bus.out_data;
                end
            end
        end
        bus.in_valid = 1'b0;
        check("busy_pulses", pulses, 1);
        check("busy_lat", first_lat, 5);
        check("busy_data", {12'h0, first_data}, 32'h00002000);

        // Reset in the middle of a long computation.
        bus.in_valid  = 1'b1;
        bus.in_data_1 = 20'h00800;
        bus.in_data_2 = 3'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("abort_out_data", {12'h0, bus.out_data}, 32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);

        req_check("after_reset", 20'h00C00, 3'd2, 20'h02400, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
